// File: rtl/noc_out_port_arbiter.sv
// rtl/noc_out_port_arbiter.sv - wormhole round-robin output-port arbiter with one-flit output register
module noc_out_port_arbiter #(
  parameter int         NUM_IN     = 5,
  parameter int         DATA_WIDTH = 32,
  parameter int         LEN_WIDTH  = 12,
  parameter logic [2:0] ID_HEADER  = 3'b001,
  parameter logic [2:0] ID_TAIL    = 3'b100
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_IN-1:0]                    in_valid_i,
  input  logic [NUM_IN-1:0]                    route_req_i,
  input  logic [NUM_IN*DATA_WIDTH-1:0]         flit_in_i,
  input  logic                                 dcts_i,
  output logic [NUM_IN-1:0]                    grant_o,
  output logic [DATA_WIDTH-1:0]                tx_o,
  output logic                                 rts_o,
  output logic                                 busy_o,
  output logic [$clog2(NUM_IN)-1:0]            owner_o,
  output logic                                 pkt_err_o
);

  localparam int IDX_W = $clog2(NUM_IN);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  tx_q, tx_d;
  logic                   rts_q, rts_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   pkt_err_q, pkt_err_d;

  logic [DATA_WIDTH-1:0]  flit [NUM_IN];
  logic [NUM_IN-1:0]      elig;
  logic                   found;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       sel_idx;
  logic [DATA_WIDTH-1:0]  sel_flit;
  logic [2:0]             sel_id;
  logic [LEN_WIDTH-1:0]   hdr_len;
  logic [LEN_WIDTH-1:0]   hdr_cnt;
  logic                   can_load;
  logic                   load;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
  endfunction

  // Unpack the head flits and mark inputs presenting a header routed here
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      flit[i] = flit_in_i[i*DATA_WIDTH +: DATA_WIDTH];
      elig[i] = in_valid_i[i] & route_req_i[i] & (flit[i][DATA_WIDTH-1 -: 3] == ID_HEADER);
    end
  end

  // Round-robin search: first eligible input at or above rr_ptr, wrapping
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_IN;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  assign can_load = !rts_q || dcts_i;
  assign sel_idx  = (state_q == S_IDLE) ? winner : owner_q;
  assign sel_flit = flit[sel_idx];
  assign sel_id   = sel_flit[DATA_WIDTH-1 -: 3];
  assign hdr_len  = sel_flit[DATA_WIDTH-4 -: LEN_WIDTH];
  // A zero length field is treated as a single-flit packet
  assign hdr_cnt  = (hdr_len == '0) ? '0 : hdr_len - 1'b1;
  assign load     = |grant_o;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      tx_q      <= '0;
      rts_q     <= 1'b0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rts_q     <= rts_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  // Next state: packet lock, length counter, round-robin pointer, output slot
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rts_d     = rts_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    pkt_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          owner_d = winner;
          cnt_d   = hdr_cnt;
          if (hdr_cnt == '0 || sel_id == ID_TAIL) begin
            rr_ptr_d = wrap_inc(winner);
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (load) begin
          cnt_d = cnt_q - 1'b1;
          // Either end condition terminates; disagreement between them is an error
          if (cnt_q == LEN_WIDTH'(1) || sel_id == ID_TAIL) begin
            state_d   = S_IDLE;
            rr_ptr_d  = wrap_inc(owner_q);
            pkt_err_d = (cnt_q == LEN_WIDTH'(1)) != (sel_id == ID_TAIL);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      tx_d  = sel_flit;
      rts_d = 1'b1;
    end else if (rts_q && dcts_i) begin
      rts_d = 1'b0;
    end
  end

  // Outputs: one-hot grant to the winner or to the locked owner, forced low in reset
  always_comb begin
    grant_o = '0;
    if (rst_ni && can_load) begin
      if (state_q == S_IDLE && found) begin
        grant_o[winner] = 1'b1;
      end else if (state_q == S_SEND && in_valid_i[owner_q]) begin
        grant_o[owner_q] = 1'b1;
      end
    end
  end

  assign tx_o      = tx_q;
  assign rts_o     = rts_q;
  assign busy_o    = (state_q == S_SEND);
  assign owner_o   = owner_q;
  assign pkt_err_o = pkt_err_q;

endmodule
